servo_pwm_multi: RTL and testbench



---
 rtl/servo_pkg.sv | 28 ++
 rtl/servo_pwm_channel.sv | 44 ++++
 rtl/servo_pwm_multi.sv | 143 ++++++++++++++
 tb/tb_servo_pwm_multi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM block: register map,
// STATUS field layout and the pulse-width clamp.
package servo_pkg;

   localparam logic [3:0] REG_CTRL       = 4'd0;
   localparam logic [3:0] REG_PERIOD     = 4'd1;
   localparam logic [3:0] REG_STATUS     = 4'd2;
   localparam logic [3:0] REG_PULSE_BASE = 4'd4;

   localparam int STATUS_CNT_LSB  = 0;
   localparam int STATUS_CNT_W    = 16;
   localparam int STATUS_PEND_BIT = 16;

   // A frame shorter than two clocks would leave no cycle between wraps.
   localparam int MIN_PERIOD = 2;

   function automatic logic [31:0] clamp_pulse(input logic [31:0] val,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
      if (val < lo) begin
         return lo;
      end else if (val > hi) begin
         return hi;
      end
      return val;
   endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: holds the active (frame-stable) pulse width and enable,
// and produces a registered output from the shared frame counter.
module servo_pwm_channel
   import servo_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter int PULSE_DEFAULT = 75000,
   parameter int MIN_PULSE     = 50000,
   parameter int MAX_PULSE     = 100000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] pulse_i,
   output logic             pwm_o
);

   logic [CNT_W-1:0] active_pulse_q, active_pulse_d;
   logic             active_en_q, active_en_d;
   logic             pwm_q;

   // The stored register keeps the raw value; only the active copy is clamped.
   assign active_pulse_d = CNT_W'(clamp_pulse(32'(pulse_i), 32'(MIN_PULSE), 32'(MAX_PULSE)));
   assign active_en_d    = en_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_pulse_q <= CNT_W'(PULSE_DEFAULT);
         active_en_q    <= 1'b0;
         pwm_q          <= 1'b0;
      end else begin
         if (load_i) begin
            active_pulse_q <= active_pulse_d;
            active_en_q    <= active_en_d;
         end
         pwm_q <= active_en_q && (count_i < active_pulse_q);
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator with an Avalon-MM register slave; all
// period/pulse/enable updates are shadowed and applied at frame boundaries.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 32,
   parameter int PERIOD_DEFAULT = 1000000,
   parameter int PULSE_DEFAULT  = 75000,
   parameter int MIN_PULSE      = 50000,
   parameter int MAX_PULSE      = 100000
) (
   input  logic              clock_clk,
   input  logic              reset_reset,
   input  logic [3:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_tick
);

   localparam logic [4:0] NUM_CH_5 = 5'(NUM_CH);

   logic [CNT_W-1:0]        count_q, count_d;
   logic [CNT_W-1:0]        period_q, period_d;
   logic [CNT_W-1:0]        active_period_q, active_period_d;
   logic [NUM_CH-1:0]       ctrl_q, ctrl_d;
   logic [CNT_W-1:0]        pulse_q [NUM_CH];
   logic [CNT_W-1:0]        pulse_d [NUM_CH];
   logic [STATUS_CNT_W-1:0] status_cnt_q, status_cnt_d;
   logic                    pending_q, pending_d;
   logic [31:0]             rdata_q, rdata_d;

   logic             boundary;
   logic [CNT_W-1:0] wdata;
   logic [3:0]       ch_off;
   logic             pulse_hit;

   assign boundary  = (count_q == active_period_q - CNT_W'(1));
   assign wdata     = avs_writedata[CNT_W-1:0];
   assign ch_off    = avs_address - REG_PULSE_BASE;
   assign pulse_hit = (avs_address >= REG_PULSE_BASE) && ({1'b0, ch_off} < NUM_CH_5);

   always_comb begin
      count_d         = boundary ? '0 : count_q + CNT_W'(1);
      active_period_d = boundary ? period_q : active_period_q;
      status_cnt_d    = boundary ? status_cnt_q + 16'd1 : status_cnt_q;
      pending_d       = boundary ? 1'b0 : pending_q;
      ctrl_d          = ctrl_q;
      period_d        = period_q;
      pulse_d         = pulse_q;
      rdata_d         = rdata_q;

      // A write landing on the boundary cycle wins over the pending clear,
      // so the flag stays set until the frame that actually uses it.
      if (avs_write) begin
         case (avs_address)
            REG_CTRL: begin
               ctrl_d    = avs_writedata[NUM_CH-1:0];
               pending_d = 1'b1;
            end
            REG_PERIOD: begin
               period_d  = (wdata < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : wdata;
               pending_d = 1'b1;
            end
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (pulse_hit && (ch_off == 4'(i))) begin
                     pulse_d[i] = wdata;
                     pending_d  = 1'b1;
                  end
               end
            end
         endcase
      end

      if (avs_read) begin
         rdata_d = '0;
         case (avs_address)
            REG_CTRL:   rdata_d = 32'(ctrl_q);
            REG_PERIOD: rdata_d = 32'(period_q);
            REG_STATUS: begin
               rdata_d[STATUS_CNT_LSB +: STATUS_CNT_W] = status_cnt_q;
               rdata_d[STATUS_PEND_BIT]                = pending_q;
            end
            default: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (pulse_hit && (ch_off == 4'(i))) begin
                     rdata_d = 32'(pulse_q[i]);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         count_q         <= '0;
         period_q        <= CNT_W'(PERIOD_DEFAULT);
         active_period_q <= CNT_W'(PERIOD_DEFAULT);
         ctrl_q          <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pulse_q[i] <= CNT_W'(PULSE_DEFAULT);
         end
         status_cnt_q    <= '0;
         pending_q       <= 1'b0;
         rdata_q         <= '0;
      end else begin
         count_q         <= count_d;
         period_q        <= period_d;
         active_period_q <= active_period_d;
         ctrl_q          <= ctrl_d;
         pulse_q         <= pulse_d;
         status_cnt_q    <= status_cnt_d;
         pending_q       <= pending_d;
         rdata_q         <= rdata_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      servo_pwm_channel #(
         .CNT_W         (CNT_W),
         .PULSE_DEFAULT (PULSE_DEFAULT),
         .MIN_PULSE     (MIN_PULSE),
         .MAX_PULSE     (MAX_PULSE)
      ) u_ch (
         .clk_i   (clock_clk),
         .rst_i   (reset_reset),
         .count_i (count_q),
         .load_i  (boundary),
         .en_i    (ctrl_q[g]),
         .pulse_i (pulse_q[g]),
         .pwm_o   (pwm_out[g])
      );
   end

   assign avs_readdata = rdata_q;
   assign frame_tick   = boundary;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: register reads via a scoreboard,
// per-frame tick spacing and per-channel high-time measurement.
module tb_servo_pwm_multi;

   localparam int NUM_CH       = 4;
   localparam int CNT_W        = 32;
   localparam int FRAME_BUDGET = 2000;

   logic              clock_clk     = 1'b0;
   logic              reset_reset   = 1'b1;
   logic [3:0]        avs_address   = '0;
   logic              avs_write     = 1'b0;
   logic [31:0]       avs_writedata = '0;
   logic              avs_read      = 1'b0;
   logic [31:0]       avs_readdata;
   logic [NUM_CH-1:0] pwm_out;
   logic              frame_tick;

   servo_pwm_multi #(
      .NUM_CH         (NUM_CH),
      .CNT_W          (CNT_W),
      .PERIOD_DEFAULT (100),
      .PULSE_DEFAULT  (50),
      .MIN_PULSE      (10),
      .MAX_PULSE      (90)
   ) dut (
      .clock_clk     (clock_clk),
      .reset_reset   (reset_reset),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .pwm_out       (pwm_out),
      .frame_tick    (frame_tick)
   );

   always #5 clock_clk = ~clock_clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] msk_q[$];
   string       tag_q[$];
   logic [31:0] frm_q[$];
   logic        rd_seen = 1'b0;

   localparam logic [31:0] ALL  = 32'hFFFF_FFFF;
   localparam logic [31:0] PEND = 32'h0001_0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Read scoreboard: expectation queued at issue, compared one cycle later.
   always @(posedge clock_clk) rd_seen <= avs_read;

   always @(negedge clock_clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            check(tag_q.pop_front(), avs_readdata & msk_q.pop_front(), exp_q.pop_front());
         end
      end
   end

   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clock_clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [3:0] addr,
                           input logic [31:0] exp, input logic [31:0] mask);
      exp_q.push_back(exp & mask);
      msk_q.push_back(mask);
      tag_q.push_back(tag);
      avs_address = addr;
      avs_read    = 1'b1;
      @(negedge clock_clk);
      avs_read    = 1'b0;
   endtask

   task automatic bus_rw(input string tag, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp);
      exp_q.push_back(exp);
      msk_q.push_back(ALL);
      tag_q.push_back(tag);
      avs_address   = addr;
      avs_writedata = wdata;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      @(negedge clock_clk);
      avs_read      = 1'b0;
      avs_write     = 1'b0;
   endtask

   task automatic expect_frame(input int len, input int h0, input int h1, input int h2, input int h3);
      frm_q.push_back(32'(len));
      frm_q.push_back(32'(h0));
      frm_q.push_back(32'(h1));
      frm_q.push_back(32'(h2));
      frm_q.push_back(32'(h3));
   endtask

   // Runs past the next frame_tick and stops on the first cycle of the new frame.
   task automatic align(input string tag, output int act);
      int n;
      n   = 0;
      act = 0;
      do begin
         @(negedge clock_clk);
         n++;
         if (pwm_out != '0) act++;
      end while (!frame_tick && n < FRAME_BUDGET);
      if (!frame_tick) check({tag, "_timeout"}, 32'd0, 32'd1);
      @(negedge clock_clk);
      if (pwm_out != '0) act++;
   endtask

   // Called on the count==0 cycle; measures one whole frame.
   task automatic measure_frame(input string tag);
      int len;
      int hi[NUM_CH];
      bit last;
      len  = 0;
      last = 1'b0;
      for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
      forever begin
         @(negedge clock_clk);
         len++;
         for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) hi[c]++;
         if (last) break;
         last = frame_tick;
         if (len > FRAME_BUDGET) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      check({tag, "_len"}, 32'(len), frm_q.pop_front());
      for (int c = 0; c < NUM_CH; c++) begin
         check($sformatf("%s_ch%0d", tag, c), 32'(hi[c]), frm_q.pop_front());
      end
   endtask

   task automatic write_on_tick(input logic [3:0] addr, input logic [31:0] data);
      int n;
      n = 0;
      do begin
         @(negedge clock_clk);
         n++;
      end while (!frame_tick && n < FRAME_BUDGET);
      if (!frame_tick) check("tick_write_timeout", 32'd0, 32'd1);
      bus_write(addr, data);
   endtask

   initial begin
      int first_tick, second_tick, act, k;

      // Reset defaults
      repeat (3) @(negedge clock_clk);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_rdata", avs_readdata, 32'd0);
      reset_reset = 1'b0;
      first_tick  = -1;
      second_tick = -1;
      act         = 0;
      for (int i = 1; i <= 250; i++) begin
         @(negedge clock_clk);
         if (pwm_out != '0) act++;
         if (frame_tick) begin
            if (first_tick < 0) first_tick = i;
            else if (second_tick < 0) second_tick = i;
         end
      end
      check("dflt_pwm_idle", 32'(act), 32'd0);
      check("dflt_first_tick", 32'(first_tick), 32'd99);
      check("dflt_tick_gap", 32'(second_tick - first_tick), 32'd100);
      bus_write(4'd3, 32'h1234);
      bus_write(4'd8, 32'h55);
      bus_write(4'd2, 32'hFFFF_FFFF);
      bus_read("dflt_status", 4'd2, 32'd2, ALL);
      bus_read("dflt_period", 4'd1, 32'd100, ALL);
      bus_read("dflt_pulse2", 4'd6, 32'd50, ALL);
      bus_read("dflt_ctrl", 4'd0, 32'd0, ALL);
      bus_read("rsvd_rd", 4'd3, 32'd0, ALL);
      bus_read("unmapped_ch_rd", 4'd8, 32'd0, ALL);

      // Enable ch0/ch2 mid-frame
      bus_write(4'd0, 32'h5);
      bus_read("en_pending_set", 4'd2, PEND, PEND);
      align("en_align", act);
      check("en_no_early_change", 32'(act), 32'd0);
      expect_frame(100, 50, 0, 50, 0);
      fork
         measure_frame("en_frame");
         begin
            repeat (40) @(negedge clock_clk);
            bus_read("en_pending_clr", 4'd2, 32'd0, PEND);
         end
      join

      // Clamping
      bus_write(4'd4, 32'd3);
      bus_write(4'd5, 32'd200);
      bus_write(4'd0, 32'h7);
      bus_read("clamp_rb0", 4'd4, 32'd3, ALL);
      bus_read("clamp_rb1", 4'd5, 32'd200, ALL);
      align("clamp_align", act);
      expect_frame(100, 10, 90, 50, 0);
      measure_frame("clamp_frame");

      // Boundary collision
      bus_write(4'd4, 32'd50);
      write_on_tick(4'd4, 32'd20);
      expect_frame(100, 50, 90, 50, 0);
      fork
         measure_frame("coll_frame1");
         begin
            repeat (40) @(negedge clock_clk);
            bus_read("coll_pending_held", 4'd2, PEND, PEND);
         end
      join
      expect_frame(100, 20, 90, 50, 0);
      fork
         measure_frame("coll_frame2");
         begin
            repeat (40) @(negedge clock_clk);
            bus_read("coll_pending_clr", 4'd2, 32'd0, PEND);
         end
      join

      // Period changes
      bus_write(4'd1, 32'd40);
      bus_read("per40_rb", 4'd1, 32'd40, ALL);
      align("per40_align", act);
      expect_frame(40, 20, 40, 40, 0);
      measure_frame("per40_frame");
      bus_write(4'd1, 32'd1);
      bus_read("per1_rb", 4'd1, 32'd2, ALL);
      align("per2_align", act);
      expect_frame(2, 2, 2, 2, 0);
      measure_frame("per2_frame_a");
      expect_frame(2, 2, 2, 2, 0);
      measure_frame("per2_frame_b");

      // Simultaneous read/write, then reset mid-pulse
      bus_write(4'd1, 32'd100);
      bus_write(4'd4, 32'd50);
      bus_rw("rw_same_addr", 4'd7, 32'd33, 32'd50);
      bus_read("rw_after", 4'd7, 32'd33, ALL);
      align("rst_align", act);
      repeat (25) @(negedge clock_clk);
      check("mid_pulse_pwm", 32'(pwm_out), 32'h7);
      reset_reset = 1'b1;
      @(negedge clock_clk);
      check("midrst_pwm", 32'(pwm_out), 32'd0);
      check("midrst_tick", 32'(frame_tick), 32'd0);
      check("midrst_rdata", avs_readdata, 32'd0);
      reset_reset = 1'b0;
      k   = 0;
      act = 0;
      do begin
         @(negedge clock_clk);
         k++;
         if (pwm_out != '0) act++;
      end while (!frame_tick && k < FRAME_BUDGET);
      check("post_rst_first_tick", 32'(k), 32'd99);
      check("post_rst_pwm_idle", 32'(act), 32'd0);
      repeat (10) @(negedge clock_clk);
      bus_read("post_rst_status", 4'd2, 32'd1, ALL);
      bus_read("post_rst_ctrl", 4'd0, 32'd0, ALL);
      bus_read("post_rst_pulse3", 4'd7, 32'd50, ALL);
      bus_read("post_rst_period", 4'd1, 32'd100, ALL);
      repeat (3) @(negedge clock_clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
